ccff_chain_loader: RTL

Configuration-chain sequencer for the routing fabric. It accepts the bitstream as words over a valid/ready handshake, serializes it LSB-first onto the configuration-chain input `ccff_head`, and produces a shift enable that gates the chain's `prog_clk` at top level. Each switch-block mux memory contributes 2 bits to the chain; for example, a 4-mux switch block gives an 8-bit chain. An optional verify pass re-shifts the same stream and compares the returning `ccff_tail` against it, so the chain's final contents are unchanged.

---
 rtl/ccff_chain_loader_if.sv | 25 ++
 rtl/ccff_chain_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word channel into the configuration-chain loader.
// Signals:
//   cfg_data  - bitstream word; bit 0 goes onto the chain first
//   cfg_valid - source has a word on cfg_data
//   cfg_ready - loader accepts the word this cycle
// The master modport is the bitstream source. The slave modport is the loader.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
) ();
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain sequencer for the routing fabric.
// The loader takes bitstream words over a valid/ready channel. It shifts each word
// LSB-first onto ccff_head and raises shift_en, which gates the chain's prog_clk.
// An optional second pass re-shifts the same stream. During that pass it compares
// ccff_tail with the bit being driven, so the chain ends up holding the same contents.
// Ports:
//   prog_clk  - programming clock, rising edge
//   pReset    - asynchronous active-low reset
//   start     - one-cycle request to begin; honoured only when idle
//   verify    - sampled with start; 1 runs the verify pass
//   cfg       - bitstream word channel (slave side)
//   ccff_head - serial bit into the chain (flop output, glitch-free)
//   ccff_tail - serial bit returning from the chain end
//   shift_en  - chain clock enable
//   busy      - high from the cycle after start through the DONE cycle
//   done      - one-cycle completion pulse
//   err       - sticky verify mismatch, cleared by an accepted start
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic                verify,
  ccff_chain_loader_if.slave  cfg,
  output logic                ccff_head,
  input  logic                ccff_tail,
  output logic                shift_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned WcntW = $clog2(WORD_W + 1);
  // Exit is decided on the last shift, before the counters wrap past their limits.
  localparam logic [CNT_W-1:0] ChainLast = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WcntW-1:0] WordLast  = WcntW'(WORD_W - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic               pass_q, pass_d;
  logic               verify_q, verify_d;
  logic               err_q, err_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WcntW-1:0]   word_cnt_q, word_cnt_d;

  logic bit_last, word_last, second_pass;

  assign bit_last    = (bit_cnt_q == ChainLast);
  assign word_last   = (word_cnt_q == WordLast);
  assign second_pass = ~pass_q & verify_q;

  // State register
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= StIdle;
      pass_q     <= 1'b0;
      verify_q   <= 1'b0;
      err_q      <= 1'b0;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      verify_q   <= verify_d;
      err_q      <= err_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (cfg.cfg_valid) state_d = StShift;
      StShift: begin
        if (bit_last) begin
          state_d = second_pass ? StFetch : StDone;
        end else if (word_last) begin
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state
  always_comb begin
    pass_d     = pass_q;
    verify_d   = verify_q;
    err_d      = err_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pass_d    = 1'b0;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          verify_d  = verify;
        end
      end
      StFetch: begin
        if (cfg.cfg_valid) begin
          sreg_d     = cfg.cfg_data;
          word_cnt_d = '0;
        end
      end
      StShift: begin
        sreg_d     = sreg_q >> 1;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        word_cnt_d = word_cnt_q + WcntW'(1);
        // ccff_head is sreg_q[0], so this compares the returning bit with the one being driven.
        if (pass_q && (ccff_tail != sreg_q[0])) err_d = 1'b1;
        if (bit_last && second_pass) begin
          pass_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    cfg.cfg_ready = 1'b0;
    shift_en      = 1'b0;
    done          = 1'b0;
    busy          = (state_q != StIdle);
    unique case (state_q)
      StFetch: cfg.cfg_ready = 1'b1;
      StShift: shift_en      = 1'b1;
      StDone:  done          = 1'b1;
      default: ;
    endcase
  end

  assign ccff_head = sreg_q[0];
  assign err       = err_q;

endmodule
